// File: rtl/sync_mem_responder.sv
// Clocked memory target for a two-phase bundled-data req/ack fetch handshake.
// req is synchronised, the transaction runs on an internal word array, then ack toggles.
module sync_mem_responder #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 32,
   parameter int SYNC_STAGES  = 2,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_async,
   input  logic                  req,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  we,
   output logic                  ack,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  busy,
   output logic                  proto_err
);

   localparam int CNT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(READ_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ACCESS, ACK} state_t;

   state_t                  state_reg, state_next;
   logic [SYNC_STAGES-1:0]  sync_reg;
   logic                    req_s;
   logic                    req_seen_reg, req_seen_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic [ADDR_WIDTH-1:0]   addr_q_reg;
   logic [DATA_WIDTH-1:0]   din_q_reg;
   logic                    we_q_reg;
   logic                    capture;
   logic                    ack_reg, ack_next;
   logic [DATA_WIDTH-1:0]   dout_reg, dout_next;
   logic                    busy_reg;
   logic                    proto_err_reg, proto_err_next;

   logic [DATA_WIDTH-1:0]   mem [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0]   rd_data_reg;
   logic [ADDR_WIDTH-1:0]   rd_addr;
   logic                    mem_we;

   assign req_s = sync_reg[SYNC_STAGES-1];

   // While idle the array is addressed straight from the bundled addr so the word
   // is already in rd_data_reg by the first ACCESS clock.
   assign rd_addr = (state_reg == IDLE) ? addr : addr_q_reg;
   assign mem_we  = (state_reg == ACCESS) && (cnt_reg == CNT_INIT) && we_q_reg;

   always_ff @(posedge clk) begin
      if (mem_we)
         mem[addr_q_reg] <= din_q_reg;
      rd_data_reg <= mem[rd_addr];
   end

   always_comb begin
      state_next     = state_reg;
      req_seen_next  = req_seen_reg;
      cnt_next       = cnt_reg;
      capture        = 1'b0;
      ack_next       = ack_reg;
      dout_next      = dout_reg;
      proto_err_next = proto_err_reg;
      case (state_reg)
         IDLE: begin
            if (req_s != req_seen_reg) begin
               capture       = 1'b1;
               req_seen_next = req_s;
               cnt_next      = CNT_INIT;
               state_next    = ACCESS;
            end
         end
         ACCESS: begin
            if (req_s != req_seen_reg)
               proto_err_next = 1'b1;
            if (cnt_reg == '0) begin
               dout_next  = we_q_reg ? din_q_reg : rd_data_reg;
               state_next = ACK;
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         ACK: begin
            if (req_s != req_seen_reg)
               proto_err_next = 1'b1;
            ack_next   = ~ack_reg;
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst_async) begin
      if (rst_async) begin
         state_reg     <= IDLE;
         sync_reg      <= '0;
         req_seen_reg  <= 1'b0;
         cnt_reg       <= '0;
         addr_q_reg    <= '0;
         din_q_reg     <= '0;
         we_q_reg      <= 1'b0;
         ack_reg       <= 1'b0;
         dout_reg      <= '0;
         busy_reg      <= 1'b0;
         proto_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         sync_reg      <= {sync_reg[SYNC_STAGES-2:0], req};
         req_seen_reg  <= req_seen_next;
         cnt_reg       <= cnt_next;
         if (capture) begin
            addr_q_reg <= addr;
            din_q_reg  <= din;
            we_q_reg   <= we;
         end
         ack_reg       <= ack_next;
         dout_reg      <= dout_next;
         // Registered copy of (state != IDLE) so busy never glitches.
         busy_reg      <= (state_next != IDLE);
         proto_err_reg <= proto_err_next;
      end
   end

   assign ack       = ack_reg;
   assign dout      = dout_reg;
   assign busy      = busy_reg;
   assign proto_err = proto_err_reg;

endmodule

// File: tb/tb_sync_mem_responder.sv
// Randomised self-checking bench for sync_mem_responder against an associative-array
// memory model and the fixed req-to-ack latency.
module tb_sync_mem_responder;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int SYNC_STAGES = 2;
   localparam int READ_LATENCY = 1;
   localparam int EXP_LAT = SYNC_STAGES + READ_LATENCY + 2;

   logic          clk = 1'b0;
   logic          rst_async = 1'b1;
   logic          req = 1'b0;
   logic [AW-1:0] addr = '0;
   logic [DW-1:0] din = '0;
   logic          we = 1'b0;
   logic          ack;
   logic [DW-1:0] dout;
   logic          busy;
   logic          proto_err;

   int n_checks = 0;
   int n_pass = 0;
   logic [DW-1:0] model_mem [int];

   sync_mem_responder #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
      .SYNC_STAGES(SYNC_STAGES), .READ_LATENCY(READ_LATENCY)
   ) dut (
      .clk(clk), .rst_async(rst_async), .req(req), .addr(addr), .din(din), .we(we),
      .ack(ack), .dout(dout), .busy(busy), .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   // One handshake: drive bundled data, toggle req, wait (bounded) for ack to move.
   task automatic do_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w,
                         output int lat, output logic [DW-1:0] dpre, output logic busy_seen);
      logic a0;
      @(negedge clk);
      a0 = ack;
      addr = a; din = d; we = w; req = ~req;
      lat = 0; busy_seen = 1'b0; dpre = '0;
      while (ack == a0 && lat < 40) begin
         dpre = dout;
         @(negedge clk);
         lat++;
         if (busy) busy_seen = 1'b1;
      end
      $display("txn %s addr=%h din=%h dout=%h lat=%0d", w ? "WR" : "RD", a, d, dout, lat);
   endtask

   // Model-checked transaction: write updates the model, dout must equal din or stored word.
   task automatic model_txn(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic w);
      int lat;
      logic [DW-1:0] dpre, exp;
      logic bs;
      if (w) model_mem[int'(a)] = d;
      exp = w ? d : model_mem[int'(a)];
      do_txn(a, d, w, lat, dpre, bs);
      check_val({tag, "_lat"}, DW'(lat), DW'(EXP_LAT));
      check_val({tag, "_dout"}, dout, exp);
      check_val({tag, "_dout_pre_ack"}, dpre, exp);
      check_val({tag, "_busy_seen"}, DW'(bs), 32'd1);
      check_val({tag, "_busy_after"}, DW'(busy), 32'd0);
   endtask

   initial begin
      int lat, acks;
      logic [DW-1:0] dpre;
      logic bs, a_prev;
      logic [AW-1:0] ra;

      // Reset held with req wiggling
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         req = ~req;
      end
      check_val("rst_ack", DW'(ack), 32'd0);
      check_val("rst_dout", dout, 32'd0);
      check_val("rst_busy", DW'(busy), 32'd0);
      check_val("rst_proto_err", DW'(proto_err), 32'd0);
      @(negedge clk);
      req = 1'b0;
      rst_async = 1'b0;
      repeat (4) @(negedge clk);
      check_val("idle_ack", DW'(ack), 32'd0);
      check_val("idle_busy", DW'(busy), 32'd0);

      // Preload and read back, with a different word written in between
      model_txn("pre5", 12'h005, 32'hDEADBEEF, 1'b1);
      model_txn("pre6", 12'h006, 32'h0BADF00D, 1'b1);
      model_txn("rd5", 12'h005, 32'h0, 1'b0);

      // Top-of-array write then read
      model_txn("wrfff", 12'hFFF, 32'h12345678, 1'b1);
      model_txn("rdfff", 12'hFFF, 32'h0, 1'b0);
      model_txn("rd000", 12'h000, 32'h0, 1'b1);

      // Fetch loop: RAM[i]=i then stream pc 0..20 back-to-back
      for (int i = 0; i <= 20; i++) begin
         model_mem[i] = DW'(i);
         do_txn(AW'(i), DW'(i), 1'b1, lat, dpre, bs);
      end
      for (int pc = 0; pc <= 20; pc++) begin
         do_txn(AW'(pc), 32'h0, 1'b0, lat, dpre, bs);
         check_val("fetch_instr", dout, DW'(pc));
         check_val("fetch_lat", DW'(lat), DW'(EXP_LAT));
      end
      check_val("fetch_proto_err", DW'(proto_err), 32'd0);

      // Random traffic on a low and a high address window
      for (int i = 0; i < 40; i++) begin
         int r;
         logic w;
         r = int'($urandom_range(0, 63));
         ra = (r < 32) ? AW'(r) : AW'(12'hFC0 + r);
         w = ($urandom_range(0, 1) == 1) || !model_mem.exists(int'(ra));
         model_txn("rand", ra, DW'($urandom), w);
      end
      check_val("rand_proto_err", DW'(proto_err), 32'd0);

      // Protocol violation: two extra req toggles one clock apart while busy
      @(negedge clk);
      a_prev = ack;
      addr = 12'h005; we = 1'b0; req = ~req;
      acks = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge clk);
         if (ack != a_prev) begin
            acks++;
            a_prev = ack;
         end
         if (k == 1 || k == 2) req = ~req;
      end
      $display("txn RD addr=005 with double req glitch, acks=%0d dout=%h", acks, dout);
      check_val("viol_ack_count", DW'(acks), 32'd1);
      check_val("viol_proto_err", DW'(proto_err), 32'd1);
      check_val("viol_dout", dout, model_mem[5]);
      check_val("viol_parity", DW'(ack), DW'(req));
      model_txn("post_viol", 12'h006, 32'h0, 1'b0);
      check_val("viol_sticky", DW'(proto_err), 32'd1);

      // Reset during ACCESS of a write to 0x010
      model_txn("pre10", 12'h010, 32'hA5A50010, 1'b1);
      @(negedge clk);
      addr = 12'h010; din = 32'hBAD0BAD0; we = 1'b1; req = ~req;
      repeat (3) @(negedge clk);
      check_val("midop_busy", DW'(busy), 32'd1);
      rst_async = 1'b1;
      req = 1'b0;
      #1;
      check_val("midop_rst_ack", DW'(ack), 32'd0);
      repeat (2) @(negedge clk);
      check_val("midop_rst_busy", DW'(busy), 32'd0);
      check_val("midop_rst_dout", dout, 32'd0);
      check_val("midop_rst_proto_err", DW'(proto_err), 32'd0);
      rst_async = 1'b0;
      repeat (2) @(negedge clk);
      model_txn("post_rst_rd10", 12'h010, 32'h0, 1'b0);
      model_txn("post_rst_rd5", 12'h005, 32'h0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
